// File: rtl/adder_8b_if.sv
// Operand/result bundle for the ripple-carry adder.
// The driver uses the master modport and the adder uses the slave modport.
interface adder_8b_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] io_A;
    logic [WIDTH-1:0] io_B;
    logic             io_Cin;
    logic [WIDTH-1:0] io_Sum;
    logic             io_Cout;

    modport master (
        output io_A,
        output io_B,
        output io_Cin,
        input  io_Sum,
        input  io_Cout
    );

    modport slave (
        input  io_A,
        input  io_B,
        input  io_Cin,
        output io_Sum,
        output io_Cout
    );
endinterface

// File: rtl/adder_8b.sv
// Parameterised ripple-carry adder: {io_Cout, io_Sum} = io_A + io_B + io_Cin.
// REG_OUT=0 gives a purely combinational adder.
// REG_OUT=1 adds one output register stage with a synchronous active-low reset.
module adder_8b #(
    parameter int WIDTH   = 8,
    parameter bit REG_OUT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    adder_8b_if.slave   bus
);
    // Carry chain: c[0] is the carry in, and c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    assign carry[0] = bus.io_Cin;

    // One full-adder cell per bit, chained from the LSB to the MSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            logic half;
            assign half          = bus.io_A[gi] ^ bus.io_B[gi];
            assign sum_next[gi]  = half ^ carry[gi];
            assign carry[gi + 1] = (bus.io_A[gi] & bus.io_B[gi]) | (carry[gi] & half);
        end
    endgenerate

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] sum_reg;
            logic             cout_reg;

            // Capture the result on each edge.
            // A low reset wins over the new result and drops it.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    sum_reg  <= '0;
                    cout_reg <= 1'b0;
                end else begin
                    sum_reg  <= sum_next;
                    cout_reg <= carry[WIDTH];
                end
            end

            assign bus.io_Sum  = sum_reg;
            assign bus.io_Cout = cout_reg;
        end else begin : g_comb
            // The clock and reset inputs have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clock, reset};

            assign bus.io_Sum  = sum_next;
            assign bus.io_Cout = carry[WIDTH];
        end
    endgenerate
endmodule

// File: tb/tb_adder_8b.sv
// Bench for adder_8b.
// It instantiates combinational builds at 8, 1 and 32 bits and a registered 8-bit build.
module tb_adder_8b;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   quiet = 1'b0;

    always #5 clock = ~clock;

    adder_8b_if #(.WIDTH(8))  bus8();
    adder_8b_if #(.WIDTH(1))  bus1();
    adder_8b_if #(.WIDTH(32)) bus32();
    adder_8b_if #(.WIDTH(8))  busr();

    adder_8b #(.WIDTH(8),  .REG_OUT(1'b0)) dut8  (.clock(clock), .reset(reset), .bus(bus8));
    adder_8b #(.WIDTH(1),  .REG_OUT(1'b0)) dut1  (.clock(clock), .reset(reset), .bus(bus1));
    adder_8b #(.WIDTH(32), .REG_OUT(1'b0)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
    adder_8b #(.WIDTH(8),  .REG_OUT(1'b1)) dutr  (.clock(clock), .reset(reset), .bus(busr));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else if (!quiet) begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'h12, 8'h34, 1'b0, 9'h046, "comb_12_34"},
        '{8'hFF, 8'h00, 1'b1, 9'h100, "ripple_ff_00_c1"},
        '{8'hFF, 8'hFF, 1'b1, 9'h1FF, "wrap_ff_ff_c1"},
        '{8'h00, 8'h00, 1'b1, 9'h001, "cin_only"},
        '{8'h80, 8'h80, 1'b0, 9'h100, "msb_carry"},
        '{8'h55, 8'hAA, 1'b0, 9'h0FF, "alt_bits"}
    };

    initial begin
        logic [63:0] ea;
        logic [63:0] eb;
        bus8.io_A = '0;  bus8.io_B = '0;  bus8.io_Cin = 1'b0;
        bus1.io_A = '0;  bus1.io_B = '0;  bus1.io_Cin = 1'b0;
        bus32.io_A = '0; bus32.io_B = '0; bus32.io_Cin = 1'b0;
        busr.io_A = '0;  busr.io_B = '0;  busr.io_Cin = 1'b0;

        // Directed combinational vectors for the 8-bit build.
        for (int i = 0; i < 6; i++) begin
            bus8.io_A = vecs[i].a; bus8.io_B = vecs[i].b; bus8.io_Cin = vecs[i].cin;
            #1;
            check(vecs[i].tag, {55'd0, bus8.io_Cout, bus8.io_Sum}, {55'd0, vecs[i].exp});
        end

        // With no output register, toggling reset leaves the outputs unchanged.
        bus8.io_A = 8'h12; bus8.io_B = 8'h34; bus8.io_Cin = 1'b0;
        reset = 1'b1; #1;
        check("comb_rst_hi", {55'd0, bus8.io_Cout, bus8.io_Sum}, 64'h046);
        reset = 1'b0; #1;
        check("comb_rst_lo", {55'd0, bus8.io_Cout, bus8.io_Sum}, 64'h046);

        // Exhaustive test of the 8-bit build.
        quiet = 1'b1;
        for (int i = 0; i < (1 << 17); i++) begin
            logic [16:0] v;
            v = i[16:0];
            bus8.io_Cin = v[16]; bus8.io_A = v[15:8]; bus8.io_B = v[7:0];
            #1;
            check("exh8", {55'd0, bus8.io_Cout, bus8.io_Sum},
                  64'(v[15:8]) + 64'(v[7:0]) + 64'(v[16]));
        end

        // Exhaustive test of the 1-bit build.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            bus1.io_Cin = v[2]; bus1.io_A = v[1]; bus1.io_B = v[0];
            #1;
            check("exh1", {62'd0, bus1.io_Cout, bus1.io_Sum},
                  64'(v[1]) + 64'(v[0]) + 64'(v[2]));
        end

        // Random draws on the 32-bit build, plus the wrap-around corner.
        for (int i = 0; i < 2000; i++) begin
            bus32.io_A = $urandom(); bus32.io_B = $urandom(); bus32.io_Cin = 1'($urandom());
            ea = 64'(bus32.io_A); eb = 64'(bus32.io_B);
            #1;
            check("rnd32", {31'd0, bus32.io_Cout, bus32.io_Sum}, ea + eb + 64'(bus32.io_Cin));
        end
        quiet = 1'b0;
        bus32.io_A = 32'hFFFF_FFFF; bus32.io_B = 32'hFFFF_FFFF; bus32.io_Cin = 1'b1;
        #1;
        check("wrap32", {31'd0, bus32.io_Cout, bus32.io_Sum}, 64'h1_FFFF_FFFF);

        // Registered build. Reset is held low across edges with all-ones operands.
        busr.io_A = 8'hFF; busr.io_B = 8'hFF; busr.io_Cin = 1'b1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("reg_reset", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h000);
        @(posedge clock); #1;
        check("reg_reset_hold", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h000);
        reset = 1'b1;
        #1;
        check("reg_release_pre", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h000);
        @(posedge clock); #1;
        check("reg_release_post", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h1FF);

        // Latency test: new operands are not visible until the next edge.
        busr.io_A = 8'h0F; busr.io_B = 8'h01; busr.io_Cin = 1'b0;
        #2;
        check("reg_lat_before", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h1FF);
        @(posedge clock); #1;
        check("reg_lat_after", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h010);

        // Back-to-back results give one result per cycle.
        busr.io_A = 8'h80; busr.io_B = 8'h80; busr.io_Cin = 1'b1;
        @(posedge clock); #1;
        check("reg_stream1", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h101);
        busr.io_A = 8'h12; busr.io_B = 8'h34; busr.io_Cin = 1'b1;
        @(posedge clock); #1;
        check("reg_stream2", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h047);

        // A reset in the middle of the stream drops the in-flight result.
        busr.io_A = 8'hF0; busr.io_B = 8'h20; busr.io_Cin = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        check("reg_mid_reset", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h000);
        reset = 1'b1;
        @(posedge clock); #1;
        check("reg_after_mid", {55'd0, busr.io_Cout, busr.io_Sum}, 64'h110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
